dac_arbiter: RTL and testbench
==============================

Name: dac_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single SPI DAC transaction engine between NREQ requesters.
- Requesters include the up/down level control, a waveform generator and a calibration loader.
- Each winning request is latched, presented to the engine as data/address/command, and started with a one-cycle dactrig.
- The block then waits for dacdone (with timeout), returns the engine's 32-bit readback and pulses a per-requester ack.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 4096, CLK50MHZ cycles allowed in WAIT before abort (>=2).

Ports:
- CLK50MHZ  in  1  system clock, 50 MHz
- RST_N  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level
- req_data  in  NREQ*12  packed 12-bit DAC codes; requester i occupies [12i+11:12i]
- req_addr  in  NREQ*4  packed DAC channel addresses
- req_cmd  in  NREQ*4  packed DAC commands
- ack  out  NREQ  one-cycle completion pulse to the granted requester
- err  out  1  one-cycle pulse, coincident with ack, when the transaction timed out
- rdata  out  32  readback captured from dac_datareceived on the last successful completion
- busy  out  1  high whenever state is not IDLE
- grant_id  out  clog2(NREQ)  index of the current or last granted requester
- data  out  12  DAC code to the engine, registered
- address  out  4  DAC address to the engine, registered
- command  out  4  DAC command to the engine, registered
- dactrig  out  1  one-cycle start pulse to the engine
- dacdone  in  1  engine completion indication
- dac_datareceived  in  32  engine shift-register readback

Behaviour:
- Reset, asynchronous on RST_N low:
  - all outputs are 0; state=IDLE; round-robin pointer=0; internal dacdone_q=0.
  - Takes effect immediately, including mid-transaction; the aborted transaction gets no ack.
- States: IDLE, TRIG, WAIT, DONE.
- IDLE: if any req bit is set, pick the first set bit at or after the pointer, wrapping modulo NREQ.
  - At that edge: latch data/address/command from the winner's slice, set grant_id, clear timeout counter, go to TRIG.
  - If no req is set, stay in IDLE.
- TRIG: dactrig=1 for exactly this cycle; go to WAIT.
- WAIT: completion is the rising edge of dacdone, i.e. dacdone=1 and dacdone_q=0.
  - dacdone held high from a previous transaction is ignored.
  - On completion: capture rdata<=dac_datareceived, go to DONE with err_next=0.
  - If the counter reaches TIMEOUT-1 without completion: go to DONE with err_next=1; rdata is unchanged.
- DONE: ack[grant_id]=1 and err=err_next for this one cycle; pointer<=(grant_id+1) mod NREQ; go to IDLE.
- Timing: earliest back-to-back re-grant is the cycle after DONE.
  - Minimum request-to-dactrig latency is 1 cycle after req is sampled.
  - Minimum dactrig-to-ack is 2 cycles, when dacdone rises in the first WAIT cycle.
- data/address/command hold their latched values from TRIG through DONE and stay unchanged in IDLE until the next grant.
- Requester contract:
  - Hold req and payload until ack.
  - Dropping req after grant does not cancel; ack still pulses.
  - Payload changes after the grant edge are ignored.
- Simultaneous requests are resolved by the pointer only; no requester wins twice while another is pending.
- dacdone activity in IDLE, TRIG or DONE is ignored apart from updating dacdone_q.
- Arithmetic:
  - Timeout counter width is clog2(TIMEOUT), saturating at TIMEOUT-1, with no wrap.
  - Pointer increment wraps modulo NREQ, including non-power-of-2 NREQ.

Decomposition:
- Shared package dac_pkg:
  - DAC_DATA_W=12, DAC_ADDR_W=4, DAC_CMD_W=4, DAC_RDATA_W=32.
  - DAC_CMD_WR_UPD=4'b0011, DAC_ADDR_ALL=4'b1111.
  - State enum dac_arb_state_t {IDLE, TRIG, WAIT, DONE}.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req, pointer. Outputs: valid, index.
  - Instantiated once; reused by later shared-resource arbiters.

Test Plan:
- Reset mid-transaction:
  - Stimulus: req[1]=1 (data=12'h800, addr=4'h0, cmd=4'h3); dacdone pulses 5 cycles after dactrig; RST_N pulsed low during WAIT, then released.
  - Before reset: exactly one dactrig, data/address/command=800/0/3 at dactrig, then ack[1] one cycle with rdata=dac_datareceived and err=0.
  - On reset: all outputs 0 immediately, no ack, next grant starts from pointer 0.
- Fairness: req=4'b1111 held, engine always completes after 3 cycles -> grant_id sequence 0,1,2,3,0; one ack per requester per round.
- Pointer wrap: pointer at 3 with req=4'b0101 -> grant 0 then 2, never 2 twice.
- Timeout: TIMEOUT=16, dacdone held 0 -> DONE after 16 WAIT cycles, ack[g]=1 with err=1, rdata unchanged (e.g. 32'hDEADBEEF from the prior transaction), next request served normally.
- Stale done: dacdone stuck high across TRIG -> no completion until dacdone falls and rises again; no early ack.
- Req drop: req[2] deasserted the cycle after grant, with payload changed to 12'hFFF -> transaction still uses the original latched data, e.g. 12'h123, and ack[2] pulses.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC transaction path.
package dac_pkg;

  localparam int unsigned DAC_DATA_W  = 12;
  localparam int unsigned DAC_ADDR_W  = 4;
  localparam int unsigned DAC_CMD_W   = 4;
  localparam int unsigned DAC_RDATA_W = 32;

  localparam logic [DAC_CMD_W-1:0]  DAC_CMD_WR_UPD = 4'b0011;
  localparam logic [DAC_ADDR_W-1:0] DAC_ADDR_ALL   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    TRIG,
    WAIT,
    DONE
  } dac_arb_state_t;

  typedef struct packed {
    logic [DAC_DATA_W-1:0] data;
    logic [DAC_ADDR_W-1:0] addr;
    logic [DAC_CMD_W-1:0]  cmd;
  } dac_xfer_t;

  // Index width for n requesters; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after the pointer.
module rr_pick
  import dac_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  pointer_i,
  output logic            valid_o,
  output logic [IDW-1:0]  index_o
);

  int unsigned cand;

  // Walk offsets from the pointer, wrapping modulo NREQ; keep the first hit.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    cand    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(pointer_i) + k) % NREQ;
      if (!valid_o && req_i[cand[IDW-1:0]]) begin
        valid_o = 1'b1;
        index_o = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/dac_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI DAC engine between NREQ requesters.
module dac_arbiter
  import dac_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                       CLK50MHZ,
  input  logic                       RST_N,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*DAC_DATA_W-1:0] req_data,
  input  logic [NREQ*DAC_ADDR_W-1:0] req_addr,
  input  logic [NREQ*DAC_CMD_W-1:0]  req_cmd,
  output logic [NREQ-1:0]            ack,
  output logic                       err,
  output logic [DAC_RDATA_W-1:0]     rdata,
  output logic                       busy,
  output logic [idx_w(NREQ)-1:0]     grant_id,
  output logic [DAC_DATA_W-1:0]      data,
  output logic [DAC_ADDR_W-1:0]      address,
  output logic [DAC_CMD_W-1:0]       command,
  output logic                       dactrig,
  input  logic                       dacdone,
  input  logic [DAC_RDATA_W-1:0]     dac_datareceived
);

  localparam int unsigned IDW  = idx_w(NREQ);
  localparam int unsigned CNTW = $clog2(TIMEOUT);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(TIMEOUT - 1);
  localparam logic [IDW-1:0]  LAST_ID = IDW'(NREQ - 1);

  dac_arb_state_t         state_q, state_d;
  dac_xfer_t              xfer_q, xfer_d;
  dac_xfer_t              win_c;
  logic [IDW-1:0]         gid_q, gid_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [DAC_RDATA_W-1:0] rdata_q, rdata_d;
  logic [NREQ-1:0]        ack_q, ack_d;
  logic                   trig_q, trig_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   dacdone_q;
  logic                   done_rise_c;
  logic                   pick_valid_c;
  logic [IDW-1:0]         pick_idx_c;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req_i     (req),
    .pointer_i (ptr_q),
    .valid_o   (pick_valid_c),
    .index_o   (pick_idx_c)
  );

  // Only a fresh rising edge counts; a level left high by an earlier transfer does not.
  assign done_rise_c = dacdone & ~dacdone_q;

  // Payload slice of the candidate winner.
  always_comb begin
    win_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx_c == IDW'(i)) begin
        win_c.data = req_data[i*DAC_DATA_W +: DAC_DATA_W];
        win_c.addr = req_addr[i*DAC_ADDR_W +: DAC_ADDR_W];
        win_c.cmd  = req_cmd[i*DAC_CMD_W +: DAC_CMD_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    xfer_d  = xfer_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    trig_d  = 1'b0;
    ack_d   = '0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid_c) begin
          state_d = TRIG;
          xfer_d  = win_c;
          gid_d   = pick_idx_c;
          cnt_d   = '0;
          trig_d  = 1'b1;
        end
      end
      TRIG: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (done_rise_c) begin
          state_d = DONE;
          rdata_d = dac_datareceived;
          ack_d   = NREQ'(1) << gid_q;
        end else if (cnt_q == CNT_MAX) begin
          state_d = DONE;
          ack_d   = NREQ'(1) << gid_q;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = (gid_q == LAST_ID) ? '0 : gid_q + IDW'(1);
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      xfer_q    <= '0;
      gid_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      trig_q    <= 1'b0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      dacdone_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      xfer_q    <= xfer_d;
      gid_q     <= gid_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      trig_q    <= trig_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      dacdone_q <= dacdone;
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;
  assign data     = xfer_q.data;
  assign address  = xfer_q.addr;
  assign command  = xfer_q.cmd;
  assign dactrig  = trig_q;

endmodule

// File: tb/tb_dac_arbiter.sv
// Bench for dac_arbiter: transaction-level model, per-cycle compare, directed scenarios.
module tb_dac_arbiter;
  import dac_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;

  logic        CLK50MHZ = 1'b0;
  logic        RST_N    = 1'b0;
  logic [3:0]  req      = '0;
  logic [47:0] req_data = '0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_cmd  = '0;
  logic [3:0]  ack;
  logic        err;
  logic [31:0] rdata;
  logic        busy;
  logic [1:0]  grant_id;
  logic [11:0] data;
  logic [3:0]  address;
  logic [3:0]  command;
  logic        dactrig;
  logic        dacdone;
  logic [31:0] drx = '0;

  logic eng_auto = 1'b1;
  logic eng_done = 1'b0;
  logic man_done = 1'b0;
  int   eng_delay = 3;
  int   eng_cd = 0;

  int checks = 0;
  int errors = 0;

  assign dacdone = eng_auto ? eng_done : man_done;

  dac_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
    .CLK50MHZ         (CLK50MHZ),
    .RST_N            (RST_N),
    .req              (req),
    .req_data         (req_data),
    .req_addr         (req_addr),
    .req_cmd          (req_cmd),
    .ack              (ack),
    .err              (err),
    .rdata            (rdata),
    .busy             (busy),
    .grant_id         (grant_id),
    .data             (data),
    .address          (address),
    .command          (command),
    .dactrig          (dactrig),
    .dacdone          (dacdone),
    .dac_datareceived (drx)
  );

  always #10 CLK50MHZ = ~CLK50MHZ;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Engine stand-in: one-cycle dacdone pulse eng_delay cycles after dactrig.
  always @(negedge CLK50MHZ) begin
    eng_done = 1'b0;
    if (dactrig) eng_cd = eng_delay;
    else if (eng_cd > 0) begin
      eng_cd--;
      if (eng_cd == 0) eng_done = 1'b1;
    end
  end

  // Transaction model: age counts edges since the grant; m_end is the age of the ack cycle.
  int          m_ptr = 0, m_gid = 0, m_age = 0, m_end = 0, m_w = 0;
  bit          m_active = 0, m_err = 0, m_prev = 0;
  logic [11:0] m_data = '0;
  logic [3:0]  m_addr = '0, m_cmd = '0;
  logic [31:0] m_rdata = '0;

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      m_ptr = 0; m_gid = 0; m_age = 0; m_end = 0; m_active = 0; m_err = 0; m_prev = 0;
      m_data = '0; m_addr = '0; m_cmd = '0; m_rdata = '0;
    end else begin
      if (!m_active) begin
        m_w = first_from(req, m_ptr);
        if (m_w >= 0) begin
          m_gid = m_w; m_active = 1; m_age = 0; m_end = 0;
          m_data = req_data[m_w*12 +: 12];
          m_addr = req_addr[m_w*4 +: 4];
          m_cmd  = req_cmd[m_w*4 +: 4];
        end
      end else if (m_end != 0 && m_age == m_end) begin
        m_active = 0;
        m_ptr = (m_gid + 1) % N;
      end else begin
        if (m_age >= 1 && m_end == 0) begin
          if (dacdone && !m_prev) begin
            m_end = m_age + 1; m_err = 0; m_rdata = drx;
          end else if (m_age == TO) begin
            m_end = m_age + 1; m_err = 1;
          end
        end
        m_age++;
      end
      m_prev = dacdone;
    end
  end

  wire m_ackcyc = m_active && m_end != 0 && m_age == m_end;

  always @(negedge CLK50MHZ) begin
    chk("busy", 32'(busy), 32'(m_active));
    chk("dactrig", 32'(dactrig), 32'(m_active && m_age == 0));
    chk("ack", 32'(ack), m_ackcyc ? (32'd1 << m_gid) : 32'd0);
    chk("err", 32'(err), 32'(m_ackcyc && m_err));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("data", 32'(data), 32'(m_data));
    chk("address", 32'(address), 32'(m_addr));
    chk("command", 32'(command), 32'(m_cmd));
    chk("rdata", rdata, m_rdata);
  end

  task automatic set_req(input int i, input logic [11:0] d, input logic [3:0] a, input logic [3:0] c);
    req_data[i*12 +: 12] = d;
    req_addr[i*4 +: 4]   = a;
    req_cmd[i*4 +: 4]    = c;
    req[i]               = 1'b1;
  endtask

  task automatic wait_trig(output int g, output int cyc);
    bit seen = 0;
    g = -1; cyc = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge CLK50MHZ);
      cyc++;
      if (dactrig) begin seen = 1; g = int'(grant_id); end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL trig_timeout: got no dactrig in 100 cycles, expected a pulse");
    end
  endtask

  task automatic wait_ack(output logic [3:0] a, output logic e, output int cyc);
    bit seen = 0;
    a = '0; e = 1'b0; cyc = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge CLK50MHZ);
      cyc++;
      if (ack != 0) begin seen = 1; a = ack; e = err; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got no ack in 100 cycles, expected a pulse");
    end
  endtask

  task automatic pulse_reset();
    @(negedge CLK50MHZ); #2 RST_N = 1'b0;
    @(negedge CLK50MHZ); RST_N = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1ms, expected completion");
    $fatal(1);
  end

  initial begin
    int g, cyc;
    logic [3:0] a;
    logic e;
    int fair_exp[5] = '{0, 1, 2, 3, 0};

    repeat (3) @(negedge CLK50MHZ);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    RST_N = 1'b1;

    // Single transfer, then reset mid-transfer.
    @(negedge CLK50MHZ);
    eng_delay = 5; drx = 32'h1111_2222;
    set_req(1, 12'h800, 4'h0, DAC_CMD_WR_UPD);
    wait_trig(g, cyc);
    chk("lat_req_trig", 32'(cyc), 32'd1);
    chk("a_gid", 32'(g), 32'd1);
    chk("a_data", 32'(data), 32'h800);
    chk("a_addr", 32'(address), 32'h0);
    chk("a_cmd", 32'(command), 32'h3);
    wait_ack(a, e, cyc);
    chk("a_ack", 32'(a), 32'b0010);
    chk("a_err", 32'(e), 32'd0);
    chk("a_rdata", rdata, 32'h1111_2222);
    req = '0;
    set_req(3, 12'h456, DAC_ADDR_ALL, 4'h2);
    wait_trig(g, cyc);
    chk("b_gid", 32'(g), 32'd3);
    repeat (2) @(negedge CLK50MHZ);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(data), 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_gid", 32'(grant_id), 32'd0);
    req = '0;
    repeat (4) @(negedge CLK50MHZ);
    RST_N = 1'b1;
    req = 4'b1010;
    wait_trig(g, cyc);
    chk("post_rst_gid", 32'(g), 32'd1);
    wait_ack(a, e, cyc);
    chk("post_rst_ack1", 32'(a), 32'b0010);
    req[1] = 1'b0;
    wait_ack(a, e, cyc);
    chk("post_rst_ack3", 32'(a), 32'b1000);
    req = '0;

    // Fairness with all requesters held.
    pulse_reset();
    eng_delay = 3;
    for (int i = 0; i < N; i++) set_req(i, 12'(12'h100 + i), 4'(i), 4'h3);
    for (int k = 0; k < 5; k++) begin
      wait_trig(g, cyc);
      chk("fair_gid", 32'(g), 32'(fair_exp[k]));
      wait_ack(a, e, cyc);
      chk("fair_ack", 32'(a), 32'd1 << fair_exp[k]);
    end
    req = '0;

    // Pointer wrap from 3 with req=0101.
    set_req(2, 12'h222, 4'h2, 4'h3);
    wait_ack(a, e, cyc);
    chk("wrap_pre_ack", 32'(a), 32'b0100);
    req = 4'b0101;
    wait_ack(a, e, cyc);
    chk("wrap_ack0", 32'(a), 32'b0001);
    req[0] = 1'b0;
    wait_ack(a, e, cyc);
    chk("wrap_ack2", 32'(a), 32'b0100);
    req = '0;

    // Minimum latency transfer, then timeout keeps old rdata.
    eng_delay = 1; drx = 32'hDEAD_BEEF;
    set_req(1, 12'h0AB, 4'h1, 4'h3);
    wait_trig(g, cyc);
    wait_ack(a, e, cyc);
    chk("min_trig_ack", 32'(cyc), 32'd2);
    chk("min_rdata", rdata, 32'hDEAD_BEEF);
    req = '0;
    eng_auto = 1'b0; man_done = 1'b0; drx = 32'h0BAD_F00D;
    set_req(3, 12'h333, 4'h3, 4'h3);
    wait_trig(g, cyc);
    wait_ack(a, e, cyc);
    chk("to_cycles", 32'(cyc), 32'd17);
    chk("to_ack", 32'(a), 32'b1000);
    chk("to_err", 32'(e), 32'd1);
    chk("to_rdata", rdata, 32'hDEAD_BEEF);
    req = '0;
    eng_auto = 1'b1; eng_delay = 2; drx = 32'h0000_5A5A;
    set_req(0, 12'h010, 4'h0, 4'h3);
    wait_ack(a, e, cyc);
    chk("after_to_ack", 32'(a), 32'b0001);
    chk("after_to_err", 32'(e), 32'd0);
    chk("after_to_rdata", rdata, 32'h0000_5A5A);
    req = '0;

    // Stale dacdone held high across TRIG.
    eng_auto = 1'b0; man_done = 1'b1; drx = 32'h7777_0001;
    repeat (2) @(negedge CLK50MHZ);
    set_req(2, 12'h444, 4'h4, 4'h3);
    wait_trig(g, cyc);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK50MHZ);
      chk("stale_noack", 32'(ack), 32'd0);
    end
    man_done = 1'b0;
    @(negedge CLK50MHZ);
    man_done = 1'b1;
    wait_ack(a, e, cyc);
    chk("stale_late_cyc", 32'(cyc), 32'd1);
    chk("stale_ack", 32'(a), 32'b0100);
    chk("stale_rdata", rdata, 32'h7777_0001);
    req = '0; man_done = 1'b0; eng_auto = 1'b1;

    // Request dropped and payload changed after grant.
    eng_delay = 4;
    set_req(2, 12'h123, 4'h5, 4'h3);
    wait_trig(g, cyc);
    req[2] = 1'b0;
    req_data[35:24] = 12'hFFF;
    wait_ack(a, e, cyc);
    chk("drop_ack", 32'(a), 32'b0100);
    chk("drop_data", 32'(data), 32'h123);
    chk("drop_addr", 32'(address), 32'h5);
    repeat (3) @(negedge CLK50MHZ);
    chk("drop_idle", 32'(busy), 32'd0);
    chk("drop_hold_data", 32'(data), 32'h123);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
